// File: rtl/buf_write_packer.sv
`timescale 1ns/1ps
// buf_write_packer
//
// Requantises per-row accumulator results from an X_MESH-row MAC array to int8
// (arithmetic shift, optional round-half-up, ReLU/leaky-1/8, saturate) and packs
// them into DATA_LEN-bit words. The words are written into one bank (pooled mode)
// or two adjacent banks (unpooled mode) of the X_MESH x X_MAC buffer array. Jobs
// walk a 2-D region: cfg_lines lines of cfg_linelen columns, with line starts
// cfg_stride words apart.
//
// Optional feature macro: ROUND_EN. When it is defined, round-half-up is applied
// on both the positive and the leaky paths. When it is undefined, plain
// arithmetic-shift truncation is used.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   cfg_valid / cfg_ready    job configuration handshake (ready only in IDLE)
//   cfg_st_addr              per-bank start word address, bank m at m*ADDR_LEN
//   cfg_stride               word-address step between lines
//   cfg_linelen, cfg_lines   output columns per line, number of lines
//   cfg_mac_sel              target bank b
//   cfg_pooled, cfg_relu     mode flags
//   cfg_shift                requant right shift
//   in_valid / in_ready      data beat handshake (ready only in RUN)
//   in_data_4                unpooled 2x2 per row, [r][j][k] at ((r*4)+(j*2)+k)*COM_DATALEN
//   in_data_1                pooled, one element per row
//   addra, data_a, wea       bank write ports, bank (r,m) at index r*X_MAC+m
//   busy, done               busy = not IDLE; done = 1-cycle end-of-job pulse
module buf_write_packer #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 13,
  parameter int DATA_LEN     = 32,
  parameter int COM_DATALEN  = 24,
  parameter int MAX_LINE_LEN = 10,
  parameter int LINE_CNT_LEN = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [ADDR_LEN*X_MAC-1:0]            cfg_st_addr,
  input  logic [ADDR_LEN-1:0]                  cfg_stride,
  input  logic [MAX_LINE_LEN-1:0]              cfg_linelen,
  input  logic [LINE_CNT_LEN-1:0]              cfg_lines,
  input  logic [$clog2(X_MAC)-1:0]             cfg_mac_sel,
  input  logic                                 cfg_pooled,
  input  logic                                 cfg_relu,
  input  logic [4:0]                           cfg_shift,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [4*COM_DATALEN*X_MESH-1:0]      in_data_4,
  input  logic [COM_DATALEN*X_MESH-1:0]        in_data_1,
  output logic [ADDR_LEN*X_MESH*X_MAC-1:0]     addra,
  output logic [DATA_LEN*X_MESH*X_MAC-1:0]     data_a,
  output logic [X_MESH*X_MAC-1:0]              wea,
  output logic                                 busy,
  output logic                                 done
);

  localparam int P      = DATA_LEN / 8;
  localparam int SEL_W  = $clog2(X_MAC);
  localparam int LANE_W = $clog2(P) + 1;
  localparam int COL_W  = MAX_LINE_LEN + 1;
  localparam int NB     = X_MESH * X_MAC;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Shift right arithmetically by sh, optionally rounding half up.
  function automatic logic signed [39:0] shift_round(input logic signed [39:0] x,
                                                     input logic [5:0] sh);
    logic signed [39:0] y;
    y = x >>> sh;
`ifdef ROUND_EN
    if (sh != 6'd0) y = y + ((x >>> (sh - 6'd1)) & 40'sd1);
`endif
    return y;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [39:0] v);
    if (v > 40'sd127)       return 8'sd127;
    else if (v < -40'sd128) return -8'sd128;
    else                    return v[7:0];
  endfunction

  // Leaky path re-shifts the original value by s+3 (slope 1/8) rather than
  // scaling the already-shifted result, so its rounding sees the true bit.
  function automatic logic signed [7:0] requant(input logic signed [COM_DATALEN-1:0] x,
                                                input logic [4:0] s,
                                                input logic relu);
    logic signed [39:0] xe;
    logic signed [39:0] y;
    xe = 40'(x);
    y  = shift_round(xe, {1'b0, s});
    if (relu && (y < 0)) y = shift_round(xe, {1'b0, s} + 6'd3);
    return sat8(y);
  endfunction

  logic [1:0]              state;
  logic [ADDR_LEN-1:0]     st_q [X_MAC];
  logic [ADDR_LEN-1:0]     stride_q;
  logic [COL_W-1:0]        linelen_q;
  logic [LINE_CNT_LEN-1:0] lines_q;
  logic [SEL_W-1:0]        sel_q;
  logic                    pooled_q;
  logic                    relu_q;
  logic [4:0]              shift_q;

  logic [COL_W-1:0]        col_q;
  logic [LINE_CNT_LEN-1:0] line_q;
  logic [LANE_W-1:0]       lane_q;
  logic [ADDR_LEN-1:0]     line_off_q;
  logic [ADDR_LEN-1:0]     word_q;

  logic [DATA_LEN-1:0]     pack0_q [X_MESH];
  logic [DATA_LEN-1:0]     pack1_q [X_MESH];
  logic [DATA_LEN-1:0]     next0   [X_MESH];
  logic [DATA_LEN-1:0]     next1   [X_MESH];

  logic [ADDR_LEN-1:0]     addra_q [NB];
  logic [DATA_LEN-1:0]     data_q  [NB];
  logic [NB-1:0]           wea_q;

  logic                    empty;
  logic                    cfg_fire;
  logic                    beat;
  logic [COL_W-1:0]        step_col;
  logic [LANE_W-1:0]       step_lane;
  logic [COL_W-1:0]        col_next;
  logic                    line_end;
  logic                    last_line;
  logic                    word_done;
  logic [SEL_W-1:0]        sel1;
  logic [ADDR_LEN-1:0]     addr0;
  logic [ADDR_LEN-1:0]     addr1;

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign empty     = (linelen_q == '0) || (lines_q == '0);
  assign in_ready  = (state == S_RUN) && !empty;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign beat      = in_valid && in_ready;

  assign step_col  = pooled_q ? COL_W'(1) : COL_W'(2);
  assign step_lane = pooled_q ? LANE_W'(1) : LANE_W'(2);
  assign col_next  = col_q + step_col;
  assign line_end  = (col_next >= linelen_q);
  assign last_line = (line_q == lines_q - LINE_CNT_LEN'(1));
  assign word_done = (lane_q + step_lane == LANE_W'(P)) || line_end;

  assign sel1  = (sel_q == SEL_W'(X_MAC - 1)) ? '0 : sel_q + SEL_W'(1);
  assign addr0 = st_q[sel_q] + line_off_q + word_q;
  assign addr1 = st_q[sel1]  + line_off_q + word_q;

  // Stage p0: combinational requant and lane insertion into the pack words.
  always_comb begin
    logic signed [7:0] yp, y00, y01, y10, y11;
    logic [15:0]       lo, hi;
    yp = '0; y00 = '0; y01 = '0; y10 = '0; y11 = '0;
    lo = '0; hi = '0;
    for (int r = 0; r < X_MESH; r++) begin
      yp  = requant(in_data_1[r*COM_DATALEN +: COM_DATALEN], shift_q, relu_q);
      y00 = requant(in_data_4[((r*4)+0)*COM_DATALEN +: COM_DATALEN], shift_q, relu_q);
      y01 = requant(in_data_4[((r*4)+1)*COM_DATALEN +: COM_DATALEN], shift_q, relu_q);
      y10 = requant(in_data_4[((r*4)+2)*COM_DATALEN +: COM_DATALEN], shift_q, relu_q);
      y11 = requant(in_data_4[((r*4)+3)*COM_DATALEN +: COM_DATALEN], shift_q, relu_q);
      lo  = pooled_q ? {8'h00, yp} : {y01, y00};
      hi  = {y11, y10};
      next0[r] = pack0_q[r] | (DATA_LEN'(lo) << {lane_q, 3'b000});
      next1[r] = pack1_q[r] | (DATA_LEN'(hi) << {lane_q, 3'b000});
    end
  end

  // Pack accumulators; cleared at job start and after every issued word so the
  // unwritten lanes of a partial word read as zero.
  always_ff @(posedge clk) begin
    for (int r = 0; r < X_MESH; r++) begin
      if (cfg_fire || (beat && word_done)) begin
        pack0_q[r] <= '0;
        pack1_q[r] <= '0;
      end else if (beat) begin
        pack0_q[r] <= next0[r];
        pack1_q[r] <= next1[r];
      end
    end
  end

  // Stage p1: control FSM and registered bank write ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      col_q      <= '0;
      line_q     <= '0;
      lane_q     <= '0;
      line_off_q <= '0;
      word_q     <= '0;
      wea_q      <= '0;
      for (int i = 0; i < NB; i++) begin
        addra_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      wea_q <= '0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            for (int m = 0; m < X_MAC; m++) st_q[m] <= cfg_st_addr[m*ADDR_LEN +: ADDR_LEN];
            stride_q   <= cfg_stride;
            // Unpooled beats carry two columns, so odd lengths round up to even.
            linelen_q  <= cfg_pooled ? COL_W'(cfg_linelen)
                                     : COL_W'(cfg_linelen) + COL_W'(cfg_linelen[0]);
            lines_q    <= cfg_lines;
            sel_q      <= cfg_mac_sel;
            pooled_q   <= cfg_pooled;
            relu_q     <= cfg_relu;
            shift_q    <= cfg_shift;
            col_q      <= '0;
            line_q     <= '0;
            lane_q     <= '0;
            line_off_q <= '0;
            word_q     <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (empty) begin
            state <= S_DONE;
          end else if (beat) begin
            if (word_done) begin
              for (int r = 0; r < X_MESH; r++) begin
                for (int m = 0; m < X_MAC; m++) begin
                  if (SEL_W'(m) == sel_q) begin
                    wea_q[r*X_MAC+m]   <= 1'b1;
                    addra_q[r*X_MAC+m] <= addr0;
                    data_q[r*X_MAC+m]  <= next0[r];
                  end else if (!pooled_q && (SEL_W'(m) == sel1)) begin
                    wea_q[r*X_MAC+m]   <= 1'b1;
                    addra_q[r*X_MAC+m] <= addr1;
                    data_q[r*X_MAC+m]  <= next1[r];
                  end
                end
              end
              word_q <= word_q + ADDR_LEN'(1);
              lane_q <= '0;
            end else begin
              lane_q <= lane_q + step_lane;
            end
            if (line_end) begin
              col_q      <= '0;
              word_q     <= '0;
              line_off_q <= line_off_q + stride_q;
              line_q     <= line_q + LINE_CNT_LEN'(1);
              if (last_line) state <= S_FLUSH;
            end else begin
              col_q <= col_next;
            end
          end
        end
        S_FLUSH: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_out
    assign addra[i*ADDR_LEN +: ADDR_LEN]  = addra_q[i];
    assign data_a[i*DATA_LEN +: DATA_LEN] = data_q[i];
  end
  assign wea = wea_q;

endmodule

// File: tb/tb_buf_write_packer.sv
`timescale 1ns/1ps
// Directed bench for buf_write_packer at default parameters (P = 4 bytes/word).
module tb_buf_write_packer;

  localparam int X_MAC = 4, X_MESH = 16, ADDR_LEN = 13, DATA_LEN = 32, CD = 24;

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic                               cfg_valid, cfg_ready;
  logic [ADDR_LEN*X_MAC-1:0]          cfg_st_addr;
  logic [ADDR_LEN-1:0]                cfg_stride;
  logic [9:0]                         cfg_linelen;
  logic [7:0]                         cfg_lines;
  logic [1:0]                         cfg_mac_sel;
  logic                               cfg_pooled, cfg_relu;
  logic [4:0]                         cfg_shift;
  logic                               in_valid, in_ready;
  logic [4*CD*X_MESH-1:0]             in_data_4;
  logic [CD*X_MESH-1:0]               in_data_1;
  logic [ADDR_LEN*X_MESH*X_MAC-1:0]   addra;
  logic [DATA_LEN*X_MESH*X_MAC-1:0]   data_a;
  logic [X_MESH*X_MAC-1:0]            wea;
  logic                               busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  buf_write_packer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_st_addr(cfg_st_addr), .cfg_stride(cfg_stride),
    .cfg_linelen(cfg_linelen), .cfg_lines(cfg_lines),
    .cfg_mac_sel(cfg_mac_sel), .cfg_pooled(cfg_pooled),
    .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_4(in_data_4), .in_data_1(in_data_1),
    .addra(addra), .data_a(data_a), .wea(wea),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_LEN-1:0] bank_addr(input int r, input int m);
    return addra[(r*X_MAC+m)*ADDR_LEN +: ADDR_LEN];
  endfunction

  function automatic logic [DATA_LEN-1:0] bank_data(input int r, input int m);
    return data_a[(r*X_MAC+m)*DATA_LEN +: DATA_LEN];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic configure(input int b, input logic pooled, input logic relu,
                           input logic [4:0] s, input logic [9:0] ll,
                           input logic [7:0] lines, input logic [12:0] stride,
                           input logic [ADDR_LEN*X_MAC-1:0] st);
    int n = 0;
    cfg_mac_sel = 2'(b); cfg_pooled = pooled; cfg_relu = relu; cfg_shift = s;
    cfg_linelen = ll; cfg_lines = lines; cfg_stride = stride; cfg_st_addr = st;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 20) begin tick(); n++; end
    chk("cfg_ready wait", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic beat();
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic set_pooled(input int base, input int rstep);
    logic [CD-1:0] v;
    for (int r = 0; r < X_MESH; r++) begin
      v = CD'(base + r*rstep);
      in_data_1[r*CD +: CD] = v;
    end
  endtask

  task automatic set_unpooled(input int base);
    for (int r = 0; r < X_MESH; r++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++)
          in_data_4[((r*4)+(j*2)+k)*CD +: CD] = CD'(base + 2*j + k);
  endtask

  task automatic check_write(input string tag, input logic [63:0] mask, input int m,
                             input logic [12:0] a, input logic [31:0] d0,
                             input logic [31:0] d15);
    chk({tag, " wea"}, wea, mask);
    chk({tag, " addr r0"}, bank_addr(0, m), a);
    chk({tag, " addr r15"}, bank_addr(15, m), a);
    chk({tag, " data r0"}, bank_data(0, m), d0);
    chk({tag, " data r15"}, bank_data(15, m), d15);
  endtask

  localparam logic [63:0] MASK_B0  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] MASK_B1  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] MASK_B2  = 64'h4444_4444_4444_4444;
  localparam logic [63:0] MASK_B30 = 64'h9999_9999_9999_9999;

  initial begin
    int ndone;
    int gap;
    logic [31:0] exp_r1;
    rst_n = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;
    cfg_st_addr = '0; cfg_stride = '0; cfg_linelen = '0; cfg_lines = '0;
    cfg_mac_sel = '0; cfg_pooled = 1'b0; cfg_relu = 1'b0; cfg_shift = '0;
    in_data_4 = '0; in_data_1 = '0;
    tick(); tick();

    // Reset state
    chk("rst wea", wea, 0);
    chk("rst addra", addra[63:0], 0);
    chk("rst data_a", data_a[63:0], 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // Pooled, b=2, st=0x10, linelen=8, one line, x = col+1+4r
    configure(2, 1'b1, 1'b0, 5'd0, 10'd8, 8'd1, 13'd0,
              {13'h300, 13'h010, 13'h200, 13'h100});
    chk("t1 busy", busy, 1);
    chk("t1 cfg_ready", cfg_ready, 0);
    for (int c = 0; c < 8; c++) begin
      set_pooled(c + 1, 4);
      beat();
      if (c == 3)      check_write("t1 w0", MASK_B2, 2, 13'h010, 32'h04030201, 32'h403F3E3D);
      else if (c == 7) check_write("t1 w1", MASK_B2, 2, 13'h011, 32'h08070605, 32'h44434241);
      else             chk("t1 no write", wea, 0);
    end
    tick();
    chk("t1 done pulse", done, 1);
    chk("t1 wea after flush", wea, 0);
    tick();
    chk("t1 done low", done, 0);
    chk("t1 cfg_ready back", cfg_ready, 1);

    // Unpooled, b=3 wraps to bank 0, linelen=8 -> two words per bank
    configure(3, 1'b0, 1'b0, 5'd0, 10'd8, 8'd1, 13'd0, '0);
    for (int i = 0; i < 4; i++) begin
      set_unpooled(1 + 4*i);
      beat();
      if (i == 1) begin
        check_write("t2 w0 b3", MASK_B30, 3, 13'h000, 32'h06050201, 32'h06050201);
        chk("t2 w0 b0 data", bank_data(0, 0), 32'h08070403);
        chk("t2 w0 b0 addr", bank_addr(7, 0), 0);
      end else if (i == 3) begin
        check_write("t2 w1 b3", MASK_B30, 3, 13'h001, 32'h0E0D0A09, 32'h0E0D0A09);
        chk("t2 w1 b0 data", bank_data(15, 0), 32'h100F0C0B);
        chk("t2 w1 b0 addr", bank_addr(15, 0), 1);
      end else begin
        chk("t2 no write", wea, 0);
      end
    end
    chk("t2 hold addr b2", bank_addr(0, 2), 13'h011);
    chk("t2 hold data b2", bank_data(0, 2), 32'h08070605);

    // Multi-line with stride, gaps in in_valid, config attempt while busy
    configure(0, 1'b1, 1'b0, 5'd0, 10'd4, 8'd3, 13'h020,
              {13'h000, 13'h000, 13'h000, 13'h100});
    cfg_valid = 1'b1; cfg_lines = 8'd0; cfg_mac_sel = 2'd2; cfg_stride = 13'h001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3 cfg_ready busy", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    for (int ln = 0; ln < 3; ln++) begin
      for (int c = 0; c < 4; c++) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("t3 gap no write", wea, 0);
        end
        set_pooled(c + 1, 0);
        beat();
        if (c == 3) check_write("t3 line", MASK_B0, 0, 13'(13'h100 + 13'h020*ln),
                                32'h04030201, 32'h04030201);
        else        chk("t3 no write", wea, 0);
      end
    end
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t3 done count", ndone, 1);

    // Partial word at line end, lane reset per line, address wrap
    configure(1, 1'b1, 1'b0, 5'd0, 10'd6, 8'd2, 13'h002,
              {13'h000, 13'h000, 13'h1FFF, 13'h000});
    for (int ln = 0; ln < 2; ln++) begin
      for (int c = 0; c < 6; c++) begin
        set_pooled(c + 1, 0);
        beat();
        if (c == 3)      check_write("t4 full", MASK_B1, 1, (ln == 0) ? 13'h1FFF : 13'h0001,
                                     32'h04030201, 32'h04030201);
        else if (c == 5) check_write("t4 partial", MASK_B1, 1, (ln == 0) ? 13'h0000 : 13'h0002,
                                     32'h00000605, 32'h00000605);
        else             chk("t4 no write", wea, 0);
      end
    end

    // Requant: s=4, relu on: 0x28, -0x100, 0x7FFFF, -0x140
`ifdef ROUND_EN
    exp_r1 = 32'hFE7FFE03;
`else
    exp_r1 = 32'hFD7FFE02;
`endif
    configure(0, 1'b1, 1'b1, 5'd4, 10'd4, 8'd1, 13'd0,
              {13'h000, 13'h000, 13'h000, 13'h055});
    set_pooled(32'h28, 0);    beat();
    set_pooled(-32'h100, 0);  beat();
    set_pooled(32'h7FFFF, 0); beat();
    set_pooled(-32'h140, 0);  beat();
    check_write("t5 relu", MASK_B0, 0, 13'h055, exp_r1, exp_r1);

    // Requant: -0x7FFFF without relu saturates to -128, single-column line
    configure(0, 1'b1, 1'b0, 5'd4, 10'd1, 8'd1, 13'd0,
              {13'h000, 13'h000, 13'h000, 13'h066});
    set_pooled(-32'h7FFFF, 0); beat();
    check_write("t5 sat", MASK_B0, 0, 13'h066, 32'h00000080, 32'h00000080);

    // Zero-length job: straight to DONE, no writes
    configure(0, 1'b1, 1'b0, 5'd0, 10'd0, 8'd5, 13'd0, '0);
    chk("t6 busy", busy, 1);
    tick();
    chk("t6 done", done, 1);
    chk("t6 no write", wea, 0);
    tick();
    chk("t6 done low", done, 0);
    chk("t6 cfg_ready", cfg_ready, 1);

    // Abort mid-line with reset
    configure(1, 1'b1, 1'b0, 5'd0, 10'd8, 8'd1, 13'd0, '0);
    set_pooled(1, 0); beat();
    set_pooled(2, 0); beat();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7 busy", busy, 0);
    chk("t7 cfg_ready", cfg_ready, 1);
    chk("t7 addra reset", bank_addr(0, 2), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7 no write", wea, 0);
      chk("t7 in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
